// File: rtl/pin_entry_ctrl.sv
// Purpose: session front end; latches the account, assembles a 4-digit BCD PIN, tracks failures/locks.
// Latency: key_enter in cycle N -> pin_valid in N+1 -> result state and auth_fail in N+2; outputs registered.
// Backpressure: none; keypad and card pulses are accepted or ignored per state. Optional macro: PIN_TIMEOUT_EN.
module pin_entry_ctrl #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        card_insert,
    input  logic        card_eject,
    input  logic [3:0]  acc_num_in,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_clear,
    input  logic        key_enter,
    input  logic        acc_found_stat,
    input  logic        acc_auth_stat,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic        pin_valid,
    output logic        session_ok,
    output logic        auth_fail,
    output logic        card_locked,
    output logic [1:0]  attempts_left,
    output logic        timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTER   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_GRANTED = 3'd3;
    localparam logic [2:0] S_REJECT  = 3'd4;
    localparam logic [2:0] S_LOCKED  = 3'd5;
    localparam logic [1:0] MAX_A     = 2'(MAX_ATTEMPTS);

    logic [2:0]  state_q, state_d;
    logic [3:0]  acc_q, acc_d;
    logic [15:0] pin_q, pin_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        found_q, found_d;
    logic [1:0]  fail_q [10];
    logic [1:0]  fail_d [10];
    logic [9:0]  lock_q, lock_d;
    logic        auth_fail_q, auth_fail_d;
    logic        pin_valid_q, session_ok_q, card_locked_q;
    logic [1:0]  attempts_q, attempts_d;
    logic        ins_locked;
    logic [1:0]  cur_fail;

`ifdef PIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;
    logic          key_evt;
`endif

    // Lock lookup for the inserted account and fail count of the latched account (accounts >= 10 have no storage).
    always_comb begin
        ins_locked = 1'b0;
        cur_fail   = 2'd0;
        for (int i = 0; i < 10; i++) begin
            if (acc_num_in == 4'(i)) ins_locked = lock_q[i];
            if (acc_q == 4'(i))      cur_fail   = fail_q[i];
        end
    end

    // Next-state logic; card_eject outranks everything, including the authenticator result.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pin_d       = pin_q;
        cnt_d       = cnt_q;
        found_d     = found_q;
        fail_d      = fail_q;
        lock_d      = lock_q;
        auth_fail_d = 1'b0;
`ifdef PIN_TIMEOUT_EN
        idle_d      = idle_q;
        timeout_d   = 1'b0;
        key_evt     = key_clear || (key_enter && cnt_q == 3'd4) ||
                      (key_valid && key_digit <= 4'd9 && cnt_q < 3'd4);
`endif
        if (card_eject && state_q != S_IDLE) begin
            state_d = S_IDLE;
            pin_d   = 16'd0;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (card_insert) begin
                        acc_d   = acc_num_in;
                        pin_d   = 16'd0;
                        cnt_d   = 3'd0;
                        state_d = (acc_num_in <= 4'd9 && ins_locked) ? S_LOCKED : S_ENTER;
                    end
                end
                S_ENTER: begin
                    if (key_clear) begin
                        pin_d = 16'd0;
                        cnt_d = 3'd0;
                    end else if (key_enter) begin
                        if (cnt_q == 3'd4) state_d = S_CHECK;
                    end else if (key_valid && key_digit <= 4'd9 && cnt_q < 3'd4) begin
                        pin_d = {pin_q[11:0], key_digit};
                        cnt_d = cnt_q + 3'd1;
                    end
`ifdef PIN_TIMEOUT_EN
                    if (key_evt) begin
                        idle_d = '0;
                    end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                        pin_d     = 16'd0;
                        cnt_d     = 3'd0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
`endif
                end
                S_CHECK: begin
                    found_d = acc_found_stat;
                    if (acc_found_stat && acc_auth_stat) begin
                        state_d = S_GRANTED;
                        for (int i = 0; i < 10; i++)
                            if (acc_q == 4'(i)) fail_d[i] = 2'd0;
                    end else begin
                        auth_fail_d = 1'b1;
                        state_d     = S_REJECT;
                        if (acc_found_stat && acc_q <= 4'd9) begin
                            for (int i = 0; i < 10; i++) begin
                                if (acc_q == 4'(i)) begin
                                    fail_d[i] = fail_q[i] + 2'd1;
                                    if (fail_q[i] + 2'd1 == MAX_A) begin
                                        lock_d[i] = 1'b1;
                                        state_d   = S_LOCKED;
                                    end
                                end
                            end
                        end
                    end
                end
                S_REJECT: begin
                    pin_d   = 16'd0;
                    cnt_d   = 3'd0;
                    state_d = found_q ? S_ENTER : S_IDLE;
                end
                default: ;
            endcase
        end
`ifdef PIN_TIMEOUT_EN
        if (state_d != S_ENTER) idle_d = '0;
`endif
    end

    // Remaining-attempts value for the state being entered, so the output is registered alongside it.
    always_comb begin
        attempts_d = 2'd0;
        if (state_d != S_IDLE && acc_d <= 4'd9) begin
            for (int i = 0; i < 10; i++)
                if (acc_d == 4'(i)) attempts_d = MAX_A - fail_d[i];
        end
    end

    // State, per-account storage and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            acc_q         <= 4'd0;
            pin_q         <= 16'd0;
            cnt_q         <= 3'd0;
            found_q       <= 1'b0;
            lock_q        <= 10'd0;
            auth_fail_q   <= 1'b0;
            pin_valid_q   <= 1'b0;
            session_ok_q  <= 1'b0;
            card_locked_q <= 1'b0;
            attempts_q    <= 2'd0;
            for (int i = 0; i < 10; i++) fail_q[i] <= 2'd0;
`ifdef PIN_TIMEOUT_EN
            idle_q        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            pin_q         <= pin_d;
            cnt_q         <= cnt_d;
            found_q       <= found_d;
            lock_q        <= lock_d;
            auth_fail_q   <= auth_fail_d;
            pin_valid_q   <= (state_d == S_CHECK);
            session_ok_q  <= (state_d == S_GRANTED);
            card_locked_q <= (state_d == S_LOCKED);
            attempts_q    <= attempts_d;
            for (int i = 0; i < 10; i++) fail_q[i] <= fail_d[i];
`ifdef PIN_TIMEOUT_EN
            idle_q        <= idle_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign acc_num       = acc_q;
    assign pin           = pin_q;
    assign pin_valid     = pin_valid_q;
    assign session_ok    = session_ok_q;
    assign auth_fail     = auth_fail_q;
    assign card_locked   = card_locked_q;
    assign attempts_left = attempts_q;
`ifdef PIN_TIMEOUT_EN
    assign timeout       = timeout_q;
`else
    // Timer not built: constant zero (TIMEOUT_CYCLES is never negative).
    assign timeout       = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/pin_entry_ctrl.md
# pin_entry_ctrl

Session front end that feeds the authenticator. Latches the account number on card insertion and assembles a 4-digit BCD PIN from keypad strokes. On enter, presents `acc_num`/`pin` to the authenticator and samples its found/authenticated result. Keeps per-account failed-attempt counters and a lock mask, and reports session grant, reject or lockout to the top-level ATM controller.

## Interface
- `MAX_ATTEMPTS`, 3: consecutive failed PIN checks before an account is locked; legal range 1..3.
- `TIMEOUT_CYCLES`, 1024: inactivity limit in ENTER; used only with `PIN_TIMEOUT_EN`.
- `clk` in 1: single clock; everything rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `card_insert` in 1: one-cycle pulse; starts a session.
- `card_eject` in 1: one-cycle pulse; ends the session.
- `acc_num_in` in 4: account number, sampled on `card_insert`.
- `key_valid` in 1: `key_digit` is valid this cycle.
- `key_digit` in 4: BCD digit; values 10..15 are ignored.
- `key_clear` in 1: pulse; discard the digits entered so far.
- `key_enter` in 1: pulse; submit the PIN.
- `acc_found_stat` in 1: from authenticator; 1 = account found.
- `acc_auth_stat` in 1: from authenticator; 1 = PIN authenticated.
- `acc_num` out 4: latched account number, to authenticator.
- `pin` out 16: assembled PIN, first digit in [15:12], to authenticator.
- `pin_valid` out 1: high during CHECK.
- `session_ok` out 1: high in GRANTED.
- `auth_fail` out 1: one-cycle pulse on a rejected PIN.
- `card_locked` out 1: high in LOCKED.
- `attempts_left` out 2: MAX_ATTEMPTS minus the fail count of the current account.
- `timeout` out 1: one-cycle pulse on inactivity abort.

## Operation
- States: IDLE, ENTER, CHECK, GRANTED, REJECT, LOCKED.
- Per-account storage: `fail_cnt[0..9]` (2 bits each) and `lock_mask[9:0]`.
  - Both persist across sessions and are cleared only by reset.
  - A successful authentication also clears that account's `fail_cnt`.
- `card_eject` in any non-IDLE state → IDLE next cycle. It has priority over every other input. Latched `pin` and digit count are cleared; counters and mask are kept.
- IDLE, `card_insert`:
  - Latch `acc_num_in`; `pin`=0; digit count=0.
  - If `acc_num_in` ≤ 9 and `lock_mask[acc_num_in]`=1 → LOCKED.
  - Otherwise → ENTER.
  - `card_insert` outside IDLE is ignored.
- ENTER:
  - Input priority: `key_clear` > `key_enter` > `key_valid`.
  - Clear: `pin`=0, count=0.
  - Enter with count==4 → CHECK. Enter with count<4 is ignored.
  - Digit ≤9 with count<4: `pin`={`pin`[11:0],digit}, count+1.
  - Digits beyond the 4th are ignored.
- CHECK (exactly one cycle, `pin_valid`=1): sample the authenticator at the end of this cycle.
  - found & auth → GRANTED; `fail_cnt`=0.
  - found & !auth → `fail_cnt`+1 and `auth_fail` pulse.
    - If the new count == MAX_ATTEMPTS → set the lock bit; → LOCKED.
    - Otherwise → REJECT.
  - !found → REJECT. No counter change, but `auth_fail` still pulses.
- REJECT (one cycle):
  - Clear `pin`/count.
  - Account found → ENTER. Account not found → IDLE.
- GRANTED / LOCKED: hold until `card_eject`.
- `attempts_left`:
  - 0 in IDLE.
  - 0 when the account number is ≥10.
  - Otherwise MAX_ATTEMPTS − `fail_cnt[acc_num]`.

## Timing
- Reset values:
  - State IDLE; all counters and `lock_mask` 0.
  - Outputs: `acc_num`=0, `pin`=0, `pin_valid`=0, `session_ok`=0, `auth_fail`=0, `card_locked`=0, `attempts_left`=0, `timeout`=0.
- All outputs are registered.
- Latencies:
  - `key_enter` at cycle N → `pin_valid` in cycle N+1.
  - Result state (GRANTED/REJECT/LOCKED) in cycle N+2.
  - `auth_fail` pulses in cycle N+2.
- The authenticator is combinational. `acc_num`/`pin` are stable during the whole CHECK cycle.
- Reset asserted mid-session → IDLE on the next edge; counters and mask are wiped.

## Configuration
- `PIN_TIMEOUT_EN` defined:
  - ENTER has an idle counter, reset by any accepted key event (digit/clear/enter).
  - At TIMEOUT_CYCLES consecutive idle cycles: one-cycle `timeout` pulse; → IDLE; `pin` cleared; `fail_cnt` unchanged.
- `PIN_TIMEOUT_EN` undefined: no counter; `timeout` tied 0; ENTER waits indefinitely.

## Test plan
- Reset, then insert acct 3; keys 1,2,3,4, enter; authenticator returns found=1, auth=1 → `pin`=16'h1234, `pin_valid` one cycle, `session_ok`=1 two cycles after enter, `attempts_left`=3.
- Acct 5, wrong PIN three times (found=1, auth=0) → `auth_fail` pulses ×3, `attempts_left` 2→1→0, LOCKED; eject then reinsert acct 5 → `card_locked`=1 immediately, no CHECK.
- Keys 9,8, enter (count 2) → ignored; then keys 7,6,5,0 (count reaches 4, 5 and 0 dropped) + simultaneous `key_clear`&`key_enter` → clear wins, `pin`=0, still ENTER.
- Digit 4'hB, then `card_eject` mid-entry → digit ignored; IDLE next cycle, `pin`=0; `fail_cnt` preserved (1 failure stays after reinsert: `attempts_left`=2).
- Account 12, PIN entered, found=0 → REJECT then IDLE, `auth_fail` pulse, no counter touched.
- With `PIN_TIMEOUT_EN`, TIMEOUT_CYCLES=8: insert, one digit, 8 idle cycles → `timeout` pulse, IDLE; without macro the block stays in ENTER after 2000 cycles.
